// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the hazard controller state encoding and the default stall length.
// A producer sitting in s1 needs three hold cycles before its result can be
// forwarded, so that is the default.
package pipeline_ctrl_pkg;

    typedef enum logic {CTRL_RUN, CTRL_STALL} ctrl_state_t;

    localparam int unsigned DEFAULT_STALL_CYCLES = 3;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: generic saturating up-counter for performance monitoring.
// Ports:
//   clk    core clock
//   rst    synchronous active-high clear
//   inc    count this cycle
//   count  current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Stop at all-ones so a long run never reports a misleadingly small number.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: turns a one-cycle data dependency pulse into a
// fixed-length s0 hold with bubbles into s1, and arbitrates that against
// memory waits (whole-pipeline freeze) and taken branches (flush s0..s2).
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   data_dependency     hazard pulse from the detector (already masked)
//   branch_taken        taken branch/jump resolved in s3
//   mem_wait            data memory not ready
//   hold_s0             s0 keeps its instruction, PC does not advance
//   bubble_s1           load a NOP into s1 instead of s0's instruction
//   freeze_all          every pipeline register holds
//   flush_s0_s2         invalidate wrong-path instructions in s0..s2
//   currently_blocked   stall in progress; masks the detector
//   stall_cycles_total  saturating count of bubble cycles
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = DEFAULT_STALL_CYCLES,
    parameter int unsigned PERF_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_dependency,
    input  logic                  branch_taken,
    input  logic                  mem_wait,
    output logic                  hold_s0,
    output logic                  bubble_s1,
    output logic                  freeze_all,
    output logic                  flush_s0_s2,
    output logic                  currently_blocked,
    output logic [PERF_WIDTH-1:0] stall_cycles_total
);

    localparam int unsigned RW = $clog2(STALL_CYCLES + 1);

    // The detection cycle is the first bubble, so STALL only has to cover the
    // remaining STALL_CYCLES-1 cycles; the counter runs down to zero on the last.
    localparam logic [RW-1:0] RELOAD = (STALL_CYCLES > 1) ? RW'(STALL_CYCLES - 2) : '0;

    ctrl_state_t   state_q, state_d;
    logic [RW-1:0] remaining_q, remaining_d;

    // Next-state and zero-latency control outputs. Reset forces every
    // control output low even though the registers only clear on the edge.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        hold_s0     = 1'b0;
        bubble_s1   = 1'b0;
        freeze_all  = 1'b0;
        flush_s0_s2 = 1'b0;
        if (!rst) begin
            unique case (state_q)
                CTRL_RUN: begin
                    if (mem_wait) begin
                        freeze_all = 1'b1;
                    end else if (branch_taken) begin
                        flush_s0_s2 = 1'b1;
                    end else if (data_dependency) begin
                        hold_s0   = 1'b1;
                        bubble_s1 = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            state_d     = CTRL_STALL;
                            remaining_d = RELOAD;
                        end
                    end
                end
                CTRL_STALL: begin
                    if (mem_wait) begin
                        // Keep the consumer parked in s0 but add no bubble:
                        // s1 is frozen too, so the stall is simply stretched.
                        freeze_all = 1'b1;
                        hold_s0    = 1'b1;
                    end else if (branch_taken) begin
                        // The flush kills the stalled consumer, so the stall is moot.
                        flush_s0_s2 = 1'b1;
                        state_d     = CTRL_RUN;
                        remaining_d = '0;
                    end else begin
                        hold_s0   = 1'b1;
                        bubble_s1 = 1'b1;
                        if (remaining_q == '0) begin
                            state_d = CTRL_RUN;
                        end else begin
                            remaining_d = remaining_q - RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = CTRL_RUN;
                end
            endcase
        end
    end

    // State and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Registered-state decode; reset only gates it low so the detector is
    // released immediately when a stall is abandoned by reset.
    assign currently_blocked = (state_q == CTRL_STALL) && !rst;

    sat_counter #(
        .WIDTH (PERF_WIDTH)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (bubble_s1),
        .count (stall_cycles_total)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: three controller instances (default, narrow counter,
// single-cycle stall) share one input stream and are each compared against a
// bubble-budget reference model every cycle.
module tb_pipeline_hazard_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dataDep = 1'b0;
    logic branchTaken = 1'b0;
    logic memWait = 1'b0;

    always #5 clk = ~clk;

    logic        holdA, bubA, frzA, flA, blkA;
    logic [15:0] totA;
    logic        holdB, bubB, frzB, flB, blkB;
    logic [3:0]  totB;
    logic        holdC, bubC, frzC, flC, blkC;
    logic [3:0]  totC;

    pipeline_hazard_controller #(.STALL_CYCLES(3), .PERF_WIDTH(16)) dutA (
        .clk(clk), .rst(rst), .data_dependency(dataDep), .branch_taken(branchTaken),
        .mem_wait(memWait), .hold_s0(holdA), .bubble_s1(bubA), .freeze_all(frzA),
        .flush_s0_s2(flA), .currently_blocked(blkA), .stall_cycles_total(totA));

    pipeline_hazard_controller #(.STALL_CYCLES(3), .PERF_WIDTH(4)) dutB (
        .clk(clk), .rst(rst), .data_dependency(dataDep), .branch_taken(branchTaken),
        .mem_wait(memWait), .hold_s0(holdB), .bubble_s1(bubB), .freeze_all(frzB),
        .flush_s0_s2(flB), .currently_blocked(blkB), .stall_cycles_total(totB));

    pipeline_hazard_controller #(.STALL_CYCLES(1), .PERF_WIDTH(4)) dutC (
        .clk(clk), .rst(rst), .data_dependency(dataDep), .branch_taken(branchTaken),
        .mem_wait(memWait), .hold_s0(holdC), .bubble_s1(bubC), .freeze_all(frzC),
        .flush_s0_s2(flC), .currently_blocked(blkC), .stall_cycles_total(totC));

    // Observed outputs per instance: {hold, bubble, freeze, flush, blocked}
    wire [4:0]  obs [3];
    wire [15:0] cnt [3];
    assign obs[0] = {holdA, bubA, frzA, flA, blkA};
    assign obs[1] = {holdB, bubB, frzB, flB, blkB};
    assign obs[2] = {holdC, bubC, frzC, flC, blkC};
    assign cnt[0] = totA;
    assign cnt[1] = {12'd0, totB};
    assign cnt[2] = {12'd0, totC};

    // Reference model: each instance owes a number of bubble cycles; a
    // dependency in an idle pipeline costs STALL_CYCLES bubbles, one of them
    // paid immediately. Memory waits postpone payment, branches cancel the debt.
    int stallLen [3] = '{3, 3, 1};
    int countMax [3] = '{65535, 15, 15};
    int owed     [3] = '{0, 0, 0};
    int total    [3] = '{0, 0, 0};
    bit countKnown [3] = '{0, 0, 0};

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every instance against the
    // model, then advance the model across the clock edge.
    task automatic applyStimulus(input logic r, input logic mw, input logic br, input logic dd);
        rst = r; memWait = mw; branchTaken = br; dataDep = dd;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic hold, bub, frz, fl, blk;
            bit   busy;
            busy = (owed[k] > 0);
            hold = 0; bub = 0; frz = 0; fl = 0; blk = 0;
            if (!r) begin
                blk = busy;
                if (mw) begin
                    frz = 1; hold = busy;
                end else if (br) begin
                    fl = 1;
                end else if (busy || dd) begin
                    hold = 1; bub = 1;
                end
            end
            checkOutput($sformatf("inst%0d.hold_s0", k),           32'(obs[k][4]), 32'(hold));
            checkOutput($sformatf("inst%0d.bubble_s1", k),         32'(obs[k][3]), 32'(bub));
            checkOutput($sformatf("inst%0d.freeze_all", k),        32'(obs[k][2]), 32'(frz));
            checkOutput($sformatf("inst%0d.flush_s0_s2", k),       32'(obs[k][1]), 32'(fl));
            checkOutput($sformatf("inst%0d.currently_blocked", k), 32'(obs[k][0]), 32'(blk));
            if (countKnown[k]) begin
                checkOutput($sformatf("inst%0d.stall_cycles_total", k), 32'(cnt[k]), 32'(total[k]));
            end
            // Advance the model.
            if (r) begin
                owed[k] = 0; total[k] = 0; countKnown[k] = 1;
            end else begin
                if (!mw) begin
                    if (br)          owed[k] = 0;
                    else if (busy)   owed[k] = owed[k] - 1;
                    else if (dd)     owed[k] = stallLen[k] - 1;
                end
                if (bub && total[k] < countMax[k]) total[k] = total[k] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset.
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        // Basic stall.
        applyStimulus(0, 0, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 0);
        // Memory wait in the middle of a stall.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        repeat (4) applyStimulus(0, 0, 0, 0);
        // Branch during a stall.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        // All three requests at once while running.
        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0);
        // Reset in the middle of a stall.
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0);
        // Twenty back-to-back stalls saturate the 4-bit counters.
        repeat (20) begin
            applyStimulus(0, 0, 0, 1);
            applyStimulus(0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
        repeat (3) applyStimulus(0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(5) == 0),
                          ($urandom_range(7) == 0), ($urandom_range(2) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
